// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 writeback path: datapath width, register
// address width, requester slot indices and the hard-wired zero register.
package msrv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Fixed requester slots on the writeback arbiter
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_CSR = 2;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/msrv32_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// after ptr_i (wrapping modulo NUM_REQ) and returns the pointer to use after
// that grant. The caller owns the pointer register.
module msrv32_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PtrW-1:0]    ptr_nxt_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  // Scan upward from ptr_i and take the first valid request
  always_comb begin
    grant_o   = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = PtrW'((int'(ptr_i) + k) % int'(NUM_REQ));
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_nxt_o    = PtrW'((int'(idx) + 1) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/msrv32_wb_arbiter.sv
// Writeback arbiter for the integer register file's single write port.
// Round-robin grant among NUM_REQ producers, registered write port, and an
// optional combinational bypass of the in-flight write onto the read ports,
// enabled by defining MSRV32_WB_FWD_EN.
module msrv32_wb_arbiter
  import msrv32_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = msrv32_pkg::XLEN
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  input  logic [NUM_REQ*5-1:0]    req_rd_addr_in,
  input  logic [NUM_REQ*XLEN-1:0] req_data_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic                    wr_en_out,
  output logic [4:0]              rd_addr_out,
  output logic [XLEN-1:0]         rd_out,
  input  logic [4:0]              rs1_addr_in,
  input  logic [4:0]              rs2_addr_in,
  input  logic [XLEN-1:0]         rf_rs1_in,
  input  logic [XLEN-1:0]         rf_rs2_in,
  output logic [XLEN-1:0]         rs1_out,
  output logic [XLEN-1:0]         rs2_out
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0]       rr_ptr_q;
  logic [PtrW-1:0]       rr_ptr_d;
  logic [NUM_REQ-1:0]    grant;
  logic                  gnt_any;
  logic [REG_ADDR_W-1:0] gnt_addr;
  logic [XLEN-1:0]       gnt_data;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [XLEN-1:0]       rd_data_q;

  msrv32_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i     (req_valid_in),
    .ptr_i     (rr_ptr_q),
    .grant_o   (grant),
    .ptr_nxt_o (rr_ptr_d)
  );

  // Nothing is accepted while reset is held, so requesters keep their requests
  assign req_ready_out = ms_riscv32_mp_rst_in ? '0 : grant;

  // One-hot select of the granted requester's address and data
  always_comb begin
    gnt_any  = |req_ready_out;
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_ready_out[i]) begin
        gnt_addr = gnt_addr | req_rd_addr_in[REG_ADDR_W*i +: REG_ADDR_W];
        gnt_data = gnt_data | req_data_in[XLEN*i +: XLEN];
      end
    end
  end

  // Pointer advance and write-port register; x0 writes are accepted but dropped
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr_q <= rr_ptr_d;
      end
      wr_en_q <= gnt_any && (gnt_addr != REG_X0);
      if (gnt_any && (gnt_addr != REG_X0)) begin
        rd_addr_q <= gnt_addr;
        rd_data_q <= gnt_data;
      end
    end
  end

  assign wr_en_out   = wr_en_q;
  assign rd_addr_out = rd_addr_q;
  assign rd_out      = rd_data_q;

`ifdef MSRV32_WB_FWD_EN
  // Bypass the write the register file has not captured yet
  always_comb begin
    rs1_out = rf_rs1_in;
    rs2_out = rf_rs2_in;
    if (wr_en_q && (rd_addr_q == rs1_addr_in) && (rs1_addr_in != REG_X0)) begin
      rs1_out = rd_data_q;
    end
    if (wr_en_q && (rd_addr_q == rs2_addr_in) && (rs2_addr_in != REG_X0)) begin
      rs2_out = rd_data_q;
    end
  end
`else
  // Read addresses only matter when bypassing
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_addr_in, rs2_addr_in};

  // Plain pass-through of register file read data
  always_comb begin
    rs1_out = rf_rs1_in;
    rs2_out = rf_rs2_in;
  end
`endif

endmodule
